// File: rtl/xbox_xlr_lcopy.sv
// Line-copy accelerator for one XBOX accelerator slot: copies LEN 256-bit lines
// between memories, one read and one write strobe per line, with SW status readback.
module xbox_xlr_lcopy #(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int REG_BASE           = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [LOG2_LINES_PER_MEM-1:0] xlr_mem_addr [NUM_MEMS],
    output logic [7:0][31:0]              xlr_mem_wdata [NUM_MEMS],
    output logic [31:0]                   xlr_mem_be [NUM_MEMS],
    output logic [NUM_MEMS-1:0]           xlr_mem_rd,
    output logic [NUM_MEMS-1:0]           xlr_mem_wr,
    input  logic [7:0][31:0]              xlr_mem_rdata [NUM_MEMS],
    input  logic [31:0]                   host_regs [32],
    input  logic [31:0]                   host_regs_valid_pulse,
    output logic [31:0]                   host_regs_data_out [32],
    output logic [31:0]                   host_regs_valid_out,
    input  logic [18:0]                   trig_soc_xmem_wr_addr,
    input  logic                          trig_soc_xmem_wr
);

    localparam int LW        = LOG2_LINES_PER_MEM;
    localparam int MW        = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
    localparam int REG_CTRL  = REG_BASE;
    localparam int REG_SRC   = REG_BASE + 1;
    localparam int REG_DST   = REG_BASE + 2;
    localparam int REG_LEN   = REG_BASE + 3;
    localparam int REG_TADDR = REG_BASE + 4;
    localparam int REG_STAT  = REG_BASE + 5;

    localparam logic [7:0]    MEM_LIMIT = 8'(NUM_MEMS);
    localparam logic [LW+1:0] LINES     = (LW + 2)'(1 << LW);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    state_t          state;
    logic [MW-1:0]   src_mem;
    logic [MW-1:0]   dst_mem;
    logic [LW-1:0]   src_line;
    logic [LW-1:0]   dst_line;
    logic [LW:0]     len;
    logic [LW-1:0]   offset;
    logic [15:0]     count;
    logic            busy;
    logic            done;
    logic            err;
    logic            aborted;
    logic            trig_en;
    logic            status_valid;

    logic            ctrl_pulse;
    logic [31:0]     ctrl;
    logic            abort_req;
    logic            sw_start;
    logic            trig_hit;
    logic            start_req;
    logic [7:0]      req_src_mem;
    logic [7:0]      req_dst_mem;
    logic [LW-1:0]   req_src_line;
    logic [LW-1:0]   req_dst_line;
    logic [LW:0]     req_len;
    logic [LW+1:0]   src_end;
    logic [LW+1:0]   dst_end;
    logic            req_err;
    logic            last_line;
    logic            unused_inputs;

    assign ctrl       = host_regs[REG_CTRL];
    assign ctrl_pulse = host_regs_valid_pulse[REG_CTRL];
    assign abort_req  = ctrl_pulse && ctrl[2];
    assign sw_start   = ctrl_pulse && ctrl[0];
    assign trig_hit   = trig_en && trig_soc_xmem_wr
                        && (trig_soc_xmem_wr_addr == host_regs[REG_TADDR][18:0]);
    // Abort beats any start in the same cycle; a start while copying is dropped.
    assign start_req  = (sw_start || trig_hit) && !abort_req && (state == IDLE);

    assign req_src_mem  = host_regs[REG_SRC][23:16];
    assign req_dst_mem  = host_regs[REG_DST][23:16];
    assign req_src_line = host_regs[REG_SRC][LW-1:0];
    assign req_dst_line = host_regs[REG_DST][LW-1:0];
    assign req_len      = host_regs[REG_LEN][LW:0];

    // Ranges that would run past the end of a memory are rejected rather than wrapped.
    assign src_end = {2'b00, req_src_line} + {1'b0, req_len};
    assign dst_end = {2'b00, req_dst_line} + {1'b0, req_len};
    assign req_err = (req_src_mem >= MEM_LIMIT) || (req_dst_mem >= MEM_LIMIT)
                     || (src_end > LINES) || (dst_end > LINES);

    assign last_line = (({1'b0, offset} + (LW + 1)'(1)) == len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            src_mem      <= '0;
            dst_mem      <= '0;
            src_line     <= '0;
            dst_line     <= '0;
            len          <= '0;
            offset       <= '0;
            count        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            aborted      <= 1'b0;
            trig_en      <= 1'b0;
            status_valid <= 1'b0;
        end else begin
            status_valid <= 1'b1;
            if (ctrl_pulse) begin
                trig_en <= ctrl[1];
            end
            case (state)
                IDLE: begin
                    if (abort_req) begin
                        aborted <= 1'b1;
                    end else if (start_req) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        aborted  <= 1'b0;
                        count    <= '0;
                        offset   <= '0;
                        src_mem  <= req_src_mem[MW-1:0];
                        dst_mem  <= req_dst_mem[MW-1:0];
                        src_line <= req_src_line;
                        dst_line <= req_dst_line;
                        len      <= req_len;
                        if (req_err) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else if (req_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RD;
                            busy  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (abort_req) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        done    <= 1'b0;
                    end else begin
                        state <= WR;
                        count <= count + 16'd1;
                    end
                end
                WR: begin
                    if (abort_req) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        done    <= 1'b0;
                    end else if (last_line) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state  <= RD;
                        offset <= offset + LW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write data is the source memory's read data passed straight through.
    always_comb begin
        for (int m = 0; m < NUM_MEMS; m++) begin
            xlr_mem_addr[m]  = '0;
            xlr_mem_wdata[m] = '0;
            xlr_mem_be[m]    = '0;
        end
        xlr_mem_rd = '0;
        xlr_mem_wr = '0;
        if (state == RD) begin
            xlr_mem_rd[src_mem]   = 1'b1;
            xlr_mem_addr[src_mem] = src_line + offset;
        end else if (state == WR) begin
            xlr_mem_wr[dst_mem]    = 1'b1;
            xlr_mem_addr[dst_mem]  = dst_line + offset;
            xlr_mem_wdata[dst_mem] = xlr_mem_rdata[src_mem];
            xlr_mem_be[dst_mem]    = '1;
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            host_regs_data_out[i] = '0;
        end
        host_regs_data_out[REG_STAT] = {count, 12'd0, aborted, err, done, busy};
    end

    assign host_regs_valid_out = {31'd0, status_valid} << REG_STAT;

    always_comb begin
        unused_inputs = ^host_regs_valid_pulse;
        for (int i = 0; i < 32; i++) begin
            unused_inputs = unused_inputs ^ (^host_regs[i]);
        end
    end

endmodule

// File: tb/tb_xbox_xlr_lcopy.sv
// Directed bench for xbox_xlr_lcopy: a schedule-level model of each copy job is
// compared against the DUT every cycle, plus literal spot checks of key results.
module tb_xbox_xlr_lcopy;

    localparam int NM    = 2;
    localparam int LW    = 8;
    localparam int RB    = 8;
    localparam int CTRL  = RB;
    localparam int SRC   = RB + 1;
    localparam int DST   = RB + 2;
    localparam int LEN   = RB + 3;
    localparam int TADDR = RB + 4;
    localparam int STAT  = RB + 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [LW-1:0]     mem_addr [NM];
    logic [7:0][31:0]  mem_wdata [NM];
    logic [31:0]       mem_be [NM];
    logic [NM-1:0]     mem_rd;
    logic [NM-1:0]     mem_wr;
    logic [7:0][31:0]  mem_rdata [NM];
    logic [31:0]       host_regs [32];
    logic [31:0]       valid_pulse;
    logic [31:0]       data_out [32];
    logic [31:0]       valid_out;
    logic [18:0]       trig_addr;
    logic              trig_wr;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int rel_cycle = 1000000;

    // Job-level model: one job at a time, described by its start cycle and stop cycle.
    int          op_t = -10;
    int          op_stop = 0;
    bit          op_copy = 1'b0;
    bit          op_ab = 1'b0;
    int          op_sm, op_sl, op_dm, op_dl;
    logic [31:0] prev_status = '0;
    logic [31:0] stat_status = '0;
    bit          trig_en_m = 1'b0;

    logic [255:0] smem [int];
    logic [255:0] rmem [int];
    logic [255:0] pend [NM];

    xbox_xlr_lcopy #(
        .NUM_MEMS(NM),
        .LOG2_LINES_PER_MEM(LW),
        .REG_BASE(RB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .xlr_mem_addr(mem_addr),
        .xlr_mem_wdata(mem_wdata),
        .xlr_mem_be(mem_be),
        .xlr_mem_rd(mem_rd),
        .xlr_mem_wr(mem_wr),
        .xlr_mem_rdata(mem_rdata),
        .host_regs(host_regs),
        .host_regs_valid_pulse(valid_pulse),
        .host_regs_data_out(data_out),
        .host_regs_valid_out(valid_out),
        .trig_soc_xmem_wr_addr(trig_addr),
        .trig_soc_xmem_wr(trig_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] pattern(int m, int l);
        logic [255:0] v;
        for (int w = 0; w < 8; w++) begin
            v[w*32 +: 32] = 32'hC0DE0000 + 32'(m * 4096 + l * 8 + w);
        end
        return v;
    endfunction

    function automatic logic [255:0] sm_rd(int m, int l);
        return smem.exists(m * 256 + l) ? smem[m * 256 + l] : pattern(m, l);
    endfunction

    function automatic logic [255:0] ref_rd(int m, int l);
        return rmem.exists(m * 256 + l) ? rmem[m * 256 + l] : pattern(m, l);
    endfunction

    // Memory slave: read data appears the cycle after the read strobe.
    always @(negedge clk) begin
        for (int m = 0; m < NM; m++) begin
            pend[m] = '0;
            if (mem_rd[m]) pend[m] = sm_rd(m, int'(mem_addr[m]));
            if (mem_wr[m]) smem[m * 256 + int'(mem_addr[m])] = mem_wdata[m];
        end
    end

    always @(posedge clk) begin
        for (int m = 0; m < NM; m++) mem_rdata[m] <= pend[m];
    end

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_busy(int c);
        return op_copy && c > op_t && c < op_stop;
    endfunction

    function automatic logic [31:0] model_status(int c);
        logic [31:0] s;
        int last;
        if (c <= op_t) return prev_status;
        if (!op_copy) return stat_status;
        last = (c < op_stop) ? c : op_stop - 1;
        s = '0;
        s[31:16] = 16'((last - op_t) / 2);
        s[0] = c < op_stop;
        s[1] = !op_ab && c >= op_stop;
        s[3] = op_ab && c >= op_stop;
        return s;
    endfunction

    task automatic model_start(int c);
        int sm, sl, dm, dl, len;
        sm  = int'(host_regs[SRC][23:16]);
        sl  = int'(host_regs[SRC][7:0]);
        dm  = int'(host_regs[DST][23:16]);
        dl  = int'(host_regs[DST][7:0]);
        len = int'(host_regs[LEN][8:0]);
        if (model_busy(c)) return;
        prev_status = model_status(c);
        op_t = c;
        if (sm >= NM || dm >= NM || sl + len > 256 || dl + len > 256) begin
            op_copy = 1'b0;
            stat_status = 32'h0000_0006;
        end else if (len == 0) begin
            op_copy = 1'b0;
            stat_status = 32'h0000_0002;
        end else begin
            op_copy = 1'b1;
            op_ab = 1'b0;
            op_stop = c + 1 + 2 * len;
            op_sm = sm; op_sl = sl; op_dm = dm; op_dl = dl;
        end
    endtask

    task automatic model_abort(int c);
        logic [31:0] s;
        if (model_busy(c)) begin
            op_ab = 1'b1;
            op_stop = c + 1;
        end else begin
            s = model_status(c);
            prev_status = s;
            s[3] = 1'b1;
            stat_status = s;
            op_copy = 1'b0;
            op_t = c;
        end
    endtask

    task automatic model_reset(int c);
        op_copy = 1'b0;
        op_t = c;
        prev_status = '0;
        stat_status = '0;
        trig_en_m = 1'b0;
    endtask

    always @(negedge clk) begin : compare
        logic [LW-1:0]  e_addr [NM];
        logic [255:0]   e_wdata [NM];
        logic [31:0]    e_be [NM];
        logic [NM-1:0]  e_rd, e_wr;
        logic [31:0]    e_stat, e_valid, other;
        int d, k;
        e_rd = '0;
        e_wr = '0;
        for (int m = 0; m < NM; m++) begin
            e_addr[m] = '0; e_wdata[m] = '0; e_be[m] = '0;
        end
        e_stat  = rst_n ? model_status(cyc) : 32'd0;
        e_valid = (rst_n && cyc > rel_cycle) ? (32'd1 << STAT) : 32'd0;
        if (rst_n && op_copy && cyc > op_t && cyc < op_stop) begin
            d = cyc - op_t;
            k = (d - 1) / 2;
            if (d % 2 == 1) begin
                e_rd[op_sm] = 1'b1;
                e_addr[op_sm] = 8'(op_sl + k);
            end else begin
                e_wr[op_dm] = 1'b1;
                e_addr[op_dm] = 8'(op_dl + k);
                e_wdata[op_dm] = ref_rd(op_sm, op_sl + k);
                e_be[op_dm] = '1;
            end
        end
        other = '0;
        for (int i = 0; i < 32; i++) if (i != STAT) other |= data_out[i];
        check_output("rd", mem_rd, e_rd);
        check_output("wr", mem_wr, e_wr);
        for (int m = 0; m < NM; m++) begin
            check_output($sformatf("addr[%0d]", m), mem_addr[m], e_addr[m]);
            check_output($sformatf("be[%0d]", m), mem_be[m], e_be[m]);
            check_output($sformatf("wdata[%0d]", m), mem_wdata[m], e_wdata[m]);
        end
        check_output("status", data_out[STAT], e_stat);
        check_output("valid_out", valid_out, e_valid);
        check_output("data_out_other", other, 32'd0);
        for (int m = 0; m < NM; m++) begin
            if (e_wr[m]) rmem[m * 256 + int'(e_addr[m])] = e_wdata[m];
        end
    end

    task automatic next_cycle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_job(int sm, int sl, int dm, int dl, int len);
        host_regs[SRC] = {8'd0, 8'(sm), 8'd0, 8'(sl)};
        host_regs[DST] = {8'd0, 8'(dm), 8'd0, 8'(dl)};
        host_regs[LEN] = 32'(len);
    endtask

    // Drives one cycle of CTRL write and/or SOC trigger, and tells the model.
    task automatic apply_stimulus(bit ctrl_wr, logic [2:0] bits, bit trig, logic [18:0] taddr);
        bit hit;
        hit = trig && trig_en_m && (taddr == host_regs[TADDR][18:0]);
        if (ctrl_wr) host_regs[CTRL] = {29'd0, bits};
        valid_pulse[CTRL] = ctrl_wr;
        trig_wr = trig;
        trig_addr = taddr;
        if (ctrl_wr && bits[2]) model_abort(cyc);
        else if ((ctrl_wr && bits[0]) || hit) model_start(cyc);
        if (ctrl_wr) trig_en_m = bits[1];
        next_cycle(1);
        valid_pulse = '0;
        trig_wr = 1'b0;
        trig_addr = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) host_regs[i] = '0;
        valid_pulse = '0;
        trig_wr = 1'b0;
        trig_addr = '0;
        rst_n = 1'b0;
        next_cycle(3);
        check_output("reset_status", data_out[STAT], 32'd0);
        check_output("reset_valid", valid_out, 32'd0);
        rst_n = 1'b1;
        rel_cycle = cyc;
        next_cycle(1);
        check_output("valid_after_release", valid_out, 32'h0000_2000);

        // Basic copy mem0 lines 4..6 -> mem1 lines 10..12
        set_job(0, 4, 1, 10, 3);
        apply_stimulus(1'b1, 3'b001, 1'b0, '0);
        check_output("first_rd_strobe", mem_rd, 2'b01);
        check_output("first_rd_addr", mem_addr[0], 8'd4);
        next_cycle(6);
        check_output("copy3_status", data_out[STAT], 32'h0003_0002);
        check_output("copy3_line12", sm_rd(1, 12), pattern(0, 6));

        // SOC trigger: mismatching address ignored, matching address starts
        set_job(1, 20, 0, 30, 2);
        host_regs[TADDR] = 32'h0000_0123;
        apply_stimulus(1'b1, 3'b010, 1'b0, '0);
        apply_stimulus(1'b0, 3'b000, 1'b1, 19'h00124);
        next_cycle(2);
        check_output("trig_miss_idle", mem_rd, 2'b00);
        apply_stimulus(1'b0, 3'b000, 1'b1, 19'h00123);
        check_output("trig_rd_strobe", mem_rd, 2'b10);
        check_output("trig_rd_addr", mem_addr[1], 8'd20);
        next_cycle(4);
        check_output("trig_status", data_out[STAT], 32'h0002_0002);
        set_job(0, 100, 1, 100, 1);
        apply_stimulus(1'b1, 3'b011, 1'b1, 19'h00123);
        next_cycle(3);
        check_output("coincident_status", data_out[STAT], 32'h0001_0002);
        apply_stimulus(1'b1, 3'b000, 1'b0, '0);
        apply_stimulus(1'b0, 3'b000, 1'b1, 19'h00123);
        next_cycle(2);

        // Range and memory-index errors, zero length, and an exact-fit range
        set_job(0, 250, 1, 0, 10);
        apply_stimulus(1'b1, 3'b001, 1'b0, '0);
        check_output("err_range_status", data_out[STAT], 32'h0000_0006);
        next_cycle(2);
        set_job(2, 0, 1, 0, 1);
        apply_stimulus(1'b1, 3'b001, 1'b0, '0);
        check_output("err_mem_status", data_out[STAT], 32'h0000_0006);
        next_cycle(2);
        set_job(0, 0, 1, 0, 0);
        apply_stimulus(1'b1, 3'b001, 1'b0, '0);
        check_output("len0_status", data_out[STAT], 32'h0000_0002);
        next_cycle(2);
        set_job(0, 250, 1, 200, 6);
        apply_stimulus(1'b1, 3'b001, 1'b0, '0);
        next_cycle(12);
        check_output("edge_fit_status", data_out[STAT], 32'h0006_0002);

        // Abort on the third write, with an ignored restart while busy
        set_job(0, 40, 1, 60, 8);
        apply_stimulus(1'b1, 3'b001, 1'b0, '0);
        next_cycle(1);
        set_job(1, 0, 0, 0, 1);
        apply_stimulus(1'b1, 3'b001, 1'b0, '0);
        next_cycle(3);
        apply_stimulus(1'b1, 3'b100, 1'b0, '0);
        check_output("abort_no_strobes", {mem_rd, mem_wr}, 4'b0000);
        next_cycle(1);
        check_output("abort_status", data_out[STAT], 32'h0003_0008);
        check_output("abort_line62", sm_rd(1, 62), pattern(0, 42));
        check_output("abort_line63", sm_rd(1, 63), pattern(1, 63));

        // Overlapping same-memory copy propagates line 0 forward
        set_job(0, 0, 0, 1, 2);
        apply_stimulus(1'b1, 3'b001, 1'b0, '0);
        next_cycle(4);
        check_output("overlap_status", data_out[STAT], 32'h0002_0002);
        check_output("overlap_line1", sm_rd(0, 1), pattern(0, 0));
        check_output("overlap_line2", sm_rd(0, 2), pattern(0, 0));
        apply_stimulus(1'b1, 3'b101, 1'b0, '0);
        check_output("start_abort_status", data_out[STAT], 32'h0002_000A);
        check_output("start_abort_no_rd", mem_rd, 2'b00);
        next_cycle(2);

        // Asynchronous reset in the middle of a copy
        set_job(1, 5, 0, 50, 8);
        apply_stimulus(1'b1, 3'b001, 1'b0, '0);
        next_cycle(2);
        #2;
        rst_n = 1'b0;
        model_reset(cyc);
        #1;
        check_output("async_rst_strobes", {mem_rd, mem_wr}, 4'b0000);
        check_output("async_rst_addr", mem_addr[1], 8'd0);
        check_output("async_rst_status", data_out[STAT], 32'd0);
        check_output("async_rst_valid", valid_out, 32'd0);
        next_cycle(2);
        rst_n = 1'b1;
        rel_cycle = cyc;
        check_output("release_valid_low", valid_out, 32'd0);
        next_cycle(1);
        check_output("release_valid_high", valid_out, 32'h0000_2000);
        check_output("partial_line50", sm_rd(0, 50), pattern(1, 5));
        check_output("partial_line51", sm_rd(0, 51), pattern(0, 51));
        next_cycle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
